pcm_playback_writer: RTL

- Software-to-DAC path. The host driver writes 24-bit PCM samples byte-by-byte over the 8-bit chipselect/write/address bus into a sample FIFO.
- The FIFO is drained one sample per audio_driver `advance` pulse onto `dac_sample`, which feeds `dac_left`/`dac_right`.
- This is the write/playback counterpart of the FFT accelerator's readout port. Byte order matches the readout port (byte 0 = bits 7:0), so software needs no htonl.

---
 rtl/pcm_playback_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pcm_playback_writer.sv
// Host-written 24-bit PCM sample FIFO drained onto the DAC on each advance rising edge.
// Optional build macro PCM_PLAYBACK_LOW_WATER_EN adds the low_water output and status bit4.
module pcm_playback_writer #(
  parameter int unsigned             DEPTH        = 512,
  parameter int unsigned             SAMPLE_WIDTH = 24,
  parameter int unsigned             PRIME_LEVEL  = 64,
  parameter logic [SAMPLE_WIDTH-1:0] MIDSCALE     = 24'h800000
`ifdef PCM_PLAYBACK_LOW_WATER_EN
  , parameter int unsigned           LOW_WATER    = 128
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              writedata,
  input  logic                    write,
  input  logic                    chipselect,
  input  logic [15:0]             address,
  output logic [7:0]              readdata,
  input  logic                    advance,
  output logic [SAMPLE_WIDTH-1:0] dac_sample,
  output logic                    playing
`ifdef PCM_PLAYBACK_LOW_WATER_EN
  , output logic                  low_water
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME_LEVEL);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  state_t                  state;
  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] staging;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    enable, flush_q, underrun, overflow, advance_q;

  logic bus_wr, commit, adv_rise, full, empty, pop, push, drop, starve;
  logic clr_underrun, clr_overflow;
  logic [15:0] count16;
  logic        lw_bit;

  // Bus decode and FIFO handshake; a pending flush discards push and pop.
  always_comb begin
    bus_wr       = chipselect & write;
    commit       = bus_wr && (address == 16'd3);
    adv_rise     = advance & ~advance_q;
    full         = (count == DEPTH_CNT);
    empty        = (count == '0);
    pop          = !flush_q && (state == PLAY) && adv_rise && !empty;
    starve       = !flush_q && (state == PLAY) && adv_rise && empty;
    push         = !flush_q && commit && (!full || pop);
    drop         = !flush_q && commit && full && !pop;
    clr_underrun = bus_wr && (address == 16'd8) && writedata[2];
    clr_overflow = bus_wr && (address == 16'd8) && writedata[3];
    count16      = 16'(count);
  end

`ifdef PCM_PLAYBACK_LOW_WATER_EN
  localparam logic [CW:0] LW_CNT = (CW+1)'(LOW_WATER);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) low_water <= 1'b0;
    else        low_water <= (state == PLAY) && ({1'b0, count} < LW_CNT);
  end
  assign lw_bit = low_water;
`else
  assign lw_bit = 1'b0;
`endif

  always_comb begin
    readdata = 8'h00;
    case (address)
      16'd4:   readdata = {7'b0, enable};
      16'd8:   readdata = {3'b0, lw_bit, overflow, underrun, empty, full};
      16'd12:  readdata = count16[7:0];
      16'd13:  readdata = count16[15:8];
      default: readdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= staging;
  end

  // Pointers, fill count and the byte staging register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      staging <= '0;
    end else if (flush_q) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      staging <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (bus_wr && (address == 16'd0)) staging[7:0]   <= writedata;
      if (bus_wr && (address == 16'd1)) staging[15:8]  <= writedata;
      if (bus_wr && (address == 16'd2)) staging[23:16] <= writedata;
    end
  end

  // Control register, flush pulse and sticky status flags; a set wins over a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable    <= 1'b0;
      flush_q   <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
      advance_q <= 1'b0;
    end else begin
      advance_q <= advance;
      flush_q   <= bus_wr && (address == 16'd4) && writedata[1];
      if (bus_wr && (address == 16'd4)) enable <= writedata[0];
      if (starve)            underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Playback FSM with registered playing flag and DAC sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      playing    <= 1'b0;
      dac_sample <= MIDSCALE;
    end else begin
      if (!enable) begin
        state   <= IDLE;
        playing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= PRIME;
            playing <= 1'b0;
          end
          PRIME: begin
            if (!flush_q && (count >= PRIME_CNT)) begin
              state   <= PLAY;
              playing <= 1'b1;
            end
          end
          PLAY: begin
            if (flush_q || starve) begin
              state   <= PRIME;
              playing <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        endcase
      end
      if (!flush_q && adv_rise) dac_sample <= pop ? mem[rd_ptr] : MIDSCALE;
    end
  end

endmodule
